// File: rtl/instr_register_calc.sv
// DEPTH-entry instruction register file with a 2-stage write pipeline that computes a signed result per entry,
// plus a registered read port forwarding from stage 1. Optional macro INSTR_REG_AUTO_PTR_EN replaces write_pointer with an internal counter.
module instr_register_calc #(
    parameter int OP_WIDTH   = 32,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int RES_WIDTH  = 2 * OP_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load_en,
    input  logic [2:0]            opcode,
    input  logic [OP_WIDTH-1:0]   operand_a,
    input  logic [OP_WIDTH-1:0]   operand_b,
    input  logic [ADDR_WIDTH-1:0] write_pointer,
    input  logic [ADDR_WIDTH-1:0] read_pointer,
    output logic [2:0]            rd_opcode,
    output logic [OP_WIDTH-1:0]   rd_op_a,
    output logic [OP_WIDTH-1:0]   rd_op_b,
    output logic [RES_WIDTH-1:0]  rd_result,
    output logic                  rd_valid,
    output logic                  rd_err
);

    typedef enum logic [2:0] {
        OPC_ZERO  = 3'd0,
        OPC_PASSA = 3'd1,
        OPC_PASSB = 3'd2,
        OPC_ADD   = 3'd3,
        OPC_SUB   = 3'd4,
        OPC_MULT  = 3'd5,
        OPC_DIV   = 3'd6,
        OPC_MOD   = 3'd7
    } opcode_t;

    // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
    localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LP_LAST  = LP_DEPTH - (ADDR_WIDTH + 1)'(1);

    logic [ADDR_WIDTH-1:0] w_wr_ptr;
    logic                  w_wr_in_range;
    logic                  w_rd_in_range;
    logic                  w_fwd_hit;

    logic                  r_s1_valid;
    logic [2:0]            r_s1_opc;
    logic [OP_WIDTH-1:0]   r_s1_a;
    logic [OP_WIDTH-1:0]   r_s1_b;
    logic [ADDR_WIDTH-1:0] r_s1_wp;

    logic signed [RES_WIDTH-1:0] w_a_ext;
    logic signed [RES_WIDTH-1:0] w_b_ext;
    logic signed [RES_WIDTH-1:0] w_res;
    logic                        w_err;

    logic [DEPTH-1:0]     r_valid;
    logic [2:0]           r_mem_opc [DEPTH];
    logic [OP_WIDTH-1:0]  r_mem_a   [DEPTH];
    logic [OP_WIDTH-1:0]  r_mem_b   [DEPTH];
    logic [RES_WIDTH-1:0] r_mem_res [DEPTH];
    logic                 r_mem_err [DEPTH];

    logic [2:0]           r_rd_opc;
    logic [OP_WIDTH-1:0]  r_rd_a;
    logic [OP_WIDTH-1:0]  r_rd_b;
    logic [RES_WIDTH-1:0] r_rd_res;
    logic                 r_rd_valid;
    logic                 r_rd_err;

`ifdef INSTR_REG_AUTO_PTR_EN
    logic [ADDR_WIDTH-1:0] r_auto_ptr;
    logic                  w_unused_wp;

    assign w_unused_wp = ^write_pointer;
    assign w_wr_ptr    = r_auto_ptr;

    // Internal write address: advances on every accepted write, wrapping at DEPTH-1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_auto_ptr <= '0;
        end else if (load_en) begin
            if ({1'b0, r_auto_ptr} == LP_LAST) begin
                r_auto_ptr <= '0;
            end else begin
                r_auto_ptr <= r_auto_ptr + ADDR_WIDTH'(1);
            end
        end
    end
`else
    assign w_wr_ptr = write_pointer;
`endif

    assign w_wr_in_range = ({1'b0, w_wr_ptr} < LP_DEPTH);
    assign w_rd_in_range = ({1'b0, read_pointer} < LP_DEPTH);
    assign w_fwd_hit     = r_s1_valid && (r_s1_wp == read_pointer);

    // Stage 1: capture the write request; out-of-range addresses never become valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_opc   <= 3'd0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_wp    <= '0;
        end else begin
            r_s1_valid <= load_en && w_wr_in_range;
            if (load_en) begin
                r_s1_opc <= opcode;
                r_s1_a   <= operand_a;
                r_s1_b   <= operand_b;
                r_s1_wp  <= w_wr_ptr;
            end
        end
    end

    // Result of the stage-1 word, shared by the stage-2 write and the read forwarding path.
    always_comb begin
        w_a_ext = {{(RES_WIDTH - OP_WIDTH){r_s1_a[OP_WIDTH-1]}}, r_s1_a};
        w_b_ext = {{(RES_WIDTH - OP_WIDTH){r_s1_b[OP_WIDTH-1]}}, r_s1_b};
        w_res   = '0;
        w_err   = 1'b0;
        case (opcode_t'(r_s1_opc))
            OPC_ZERO:  w_res = '0;
            OPC_PASSA: w_res = w_a_ext;
            OPC_PASSB: w_res = w_b_ext;
            OPC_ADD:   w_res = w_a_ext + w_b_ext;
            OPC_SUB:   w_res = w_a_ext - w_b_ext;
            OPC_MULT:  w_res = w_a_ext * w_b_ext;
            OPC_DIV: begin
                if (w_b_ext == '0) begin
                    w_err = 1'b1;
                    w_res = '0;
                end else begin
                    w_res = w_a_ext / w_b_ext;
                end
            end
            OPC_MOD: begin
                if (w_b_ext == '0) begin
                    w_err = 1'b1;
                    w_res = '0;
                end else begin
                    w_res = w_a_ext % w_b_ext;
                end
            end
            default: w_res = '0;
        endcase
    end

    // Stage 2 storage: entry contents are qualified by r_valid, so they need no reset.
    always_ff @(posedge clk) begin
        if (r_s1_valid) begin
            r_mem_opc[r_s1_wp] <= r_s1_opc;
            r_mem_a[r_s1_wp]   <= r_s1_a;
            r_mem_b[r_s1_wp]   <= r_s1_b;
            r_mem_res[r_s1_wp] <= w_res;
            r_mem_err[r_s1_wp] <= w_err;
        end
    end

    // Per-entry written-since-reset flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
        end else if (r_s1_valid) begin
            r_valid[r_s1_wp] <= 1'b1;
        end
    end

    // Registered read port: range check, then stage-1 forwarding, then stored entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_opc   <= 3'd0;
            r_rd_a     <= '0;
            r_rd_b     <= '0;
            r_rd_res   <= '0;
            r_rd_valid <= 1'b0;
            r_rd_err   <= 1'b0;
        end else if (!w_rd_in_range) begin
            r_rd_opc   <= 3'd0;
            r_rd_a     <= '0;
            r_rd_b     <= '0;
            r_rd_res   <= '0;
            r_rd_valid <= 1'b0;
            r_rd_err   <= 1'b0;
        end else if (w_fwd_hit) begin
            r_rd_opc   <= r_s1_opc;
            r_rd_a     <= r_s1_a;
            r_rd_b     <= r_s1_b;
            r_rd_res   <= w_res;
            r_rd_valid <= 1'b1;
            r_rd_err   <= w_err;
        end else if (!r_valid[read_pointer]) begin
            r_rd_opc   <= 3'd0;
            r_rd_a     <= '0;
            r_rd_b     <= '0;
            r_rd_res   <= '0;
            r_rd_valid <= 1'b0;
            r_rd_err   <= 1'b0;
        end else begin
            r_rd_opc   <= r_mem_opc[read_pointer];
            r_rd_a     <= r_mem_a[read_pointer];
            r_rd_b     <= r_mem_b[read_pointer];
            r_rd_res   <= r_mem_res[read_pointer];
            r_rd_valid <= 1'b1;
            r_rd_err   <= r_mem_err[read_pointer];
        end
    end

    assign rd_opcode = r_rd_opc;
    assign rd_op_a   = r_rd_a;
    assign rd_op_b   = r_rd_b;
    assign rd_result = r_rd_res;
    assign rd_valid  = r_rd_valid;
    assign rd_err    = r_rd_err;

endmodule

// File: tb/tb_instr_register_calc.sv
// Self-checking bench for instr_register_calc: directed scenarios plus randomized traffic against a behavioural model.
// With INSTR_REG_AUTO_PTR_EN defined it builds DEPTH=4 and checks the internal write counter instead.
module tb_instr_register_calc;

`ifdef INSTR_REG_AUTO_PTR_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 20;
`endif
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic          clk;
    logic          reset_n;
    logic          load_en;
    logic [2:0]    opcode;
    logic [31:0]   operand_a;
    logic [31:0]   operand_b;
    logic [AW-1:0] write_pointer;
    logic [AW-1:0] read_pointer;
    logic [2:0]    rd_opcode;
    logic [31:0]   rd_op_a;
    logic [31:0]   rd_op_b;
    logic [63:0]   rd_result;
    logic          rd_valid;
    logic          rd_err;

    instr_register_calc #(.OP_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .load_en(load_en), .opcode(opcode),
        .operand_a(operand_a), .operand_b(operand_b),
        .write_pointer(write_pointer), .read_pointer(read_pointer),
        .rd_opcode(rd_opcode), .rd_op_a(rd_op_a), .rd_op_b(rd_op_b),
        .rd_result(rd_result), .rd_valid(rd_valid), .rd_err(rd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: what each entry holds, as seen by a read.
    bit         m_valid [DEPTH];
    logic [2:0] m_opc   [DEPTH];
    int         m_a     [DEPTH];
    int         m_b     [DEPTH];
    longint     m_res   [DEPTH];
    bit         m_err   [DEPTH];
`ifdef INSTR_REG_AUTO_PTR_EN
    int unsigned m_ptr = 0;
`endif
    logic [132:0] e_tuple;
    logic [132:0] o_tuple;

    function automatic longint ref_result(input logic [2:0] opc, input int a, input int b, output bit err);
        longint la = a;
        longint lb = b;
        err = 1'b0;
        case (opc)
            3'd1: return la;
            3'd2: return lb;
            3'd3: return la + lb;
            3'd4: return la - lb;
            3'd5: return la * lb;
            3'd6: begin if (b == 0) begin err = 1'b1; return 0; end return la / lb; end
            3'd7: begin if (b == 0) begin err = 1'b1; return 0; end return la % lb; end
            default: return 0;
        endcase
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
`ifdef INSTR_REG_AUTO_PTR_EN
        m_ptr = 0;
`endif
    endtask

    // One clock: drive inputs, take the edge, form the expected read (writes from earlier edges only),
    // then fold this edge's write into the model. Leaves time at edge+1.
    task automatic drive_cycle(input bit ld, input logic [2:0] opc, input int a, input int b,
                               input int unsigned wp, input int unsigned rp);
        int unsigned eff_wp;
        bit e;
        load_en = ld; opcode = opc; operand_a = a; operand_b = b;
        write_pointer = wp[AW-1:0]; read_pointer = rp[AW-1:0];
        @(posedge clk);
        if (rp < DEPTH && m_valid[rp])
            e_tuple = {1'b1, m_err[rp], m_opc[rp], m_a[rp], m_b[rp], m_res[rp]};
        else
            e_tuple = '0;
`ifdef INSTR_REG_AUTO_PTR_EN
        eff_wp = m_ptr;
        if (ld) m_ptr = (m_ptr + 1) % DEPTH;
`else
        eff_wp = wp;
`endif
        if (ld && eff_wp < DEPTH) begin
            m_valid[eff_wp] = 1'b1;
            m_opc[eff_wp]   = opc;
            m_a[eff_wp]     = a;
            m_b[eff_wp]     = b;
            m_res[eff_wp]   = ref_result(opc, a, b, e);
            m_err[eff_wp]   = e;
        end
        #1;
        o_tuple = {rd_valid, rd_err, rd_opcode, rd_op_a, rd_op_b, rd_result};
    endtask

    task automatic test_reset();
        load_en = 1'b0; opcode = 3'd0; operand_a = '0; operand_b = '0;
        write_pointer = '0; read_pointer = '0;
        reset_n = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({rd_valid, rd_err, rd_opcode, rd_op_a, rd_op_b, rd_result} !== 133'd0) begin
            n_fail++;
            $display("FAIL reset_hold: got %h required 0", {rd_valid, rd_err, rd_opcode, rd_op_a, rd_op_b, rd_result});
        end
        reset_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            drive_cycle(1'b0, 3'd0, 0, 0, 0, i);
            n_tests++;
            if (o_tuple !== 133'd0) begin
                n_fail++;
                $display("FAIL reset_sweep[%0d]: got %h required 0", i, o_tuple);
            end
        end
    endtask

`ifdef INSTR_REG_AUTO_PTR_EN
    task automatic test_auto_ptr();
        longint exp_c [4] = '{64'sd5, 64'sd2, 64'sd3, 64'sd4};
        for (int i = 1; i <= 5; i++) drive_cycle(1'b1, 3'd2, 0, i, 3, 0);
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, 3'd0, 0, 0, 3, i);
            n_tests++;
            if (rd_valid !== 1'b1 || rd_result !== exp_c[i] || o_tuple !== e_tuple) begin
                n_fail++;
                $display("FAIL auto_ptr[%0d]: got valid=%b result=%0d required valid=1 result=%0d", i, rd_valid, $signed(rd_result), exp_c[i]);
            end
        end
    endtask
`else
    task automatic test_arith();
        longint exp_c [4] = '{-64'sd8, -64'sd15, -64'sd3, -64'sd1};
        drive_cycle(1'b1, 3'd3, -15, 7, 0, 19);
        drive_cycle(1'b1, 3'd5, -3, 5, 1, 19);
        drive_cycle(1'b1, 3'd6, -7, 2, 2, 19);
        drive_cycle(1'b1, 3'd7, -7, 2, 3, 19);
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, 3'd0, 0, 0, 0, i);
            n_tests++;
            if (rd_result !== exp_c[i] || rd_err !== 1'b0 || rd_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL arith[%0d]: got result=%0d err=%b valid=%b required result=%0d err=0 valid=1", i, $signed(rd_result), rd_err, rd_valid, exp_c[i]);
            end
            n_tests++;
            if (o_tuple !== e_tuple) begin
                n_fail++;
                $display("FAIL arith_model[%0d]: got %h required %h", i, o_tuple, e_tuple);
            end
        end
    endtask

    task automatic test_zero_div();
        drive_cycle(1'b1, 3'd6, 9, 0, 4, 19);
        drive_cycle(1'b1, 3'd7, 9, 0, 5, 19);
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b0, 3'd0, 0, 0, 0, 4 + i);
            n_tests++;
            if ({rd_valid, rd_err, rd_opcode, rd_op_a, rd_op_b, rd_result} !== {1'b1, 1'b1, 3'(6 + i), 32'd9, 32'd0, 64'd0}) begin
                n_fail++;
                $display("FAIL zero_div[%0d]: got valid=%b err=%b opc=%0d a=%0d b=%0d result=%0d required 1 1 %0d 9 0 0", i, rd_valid, rd_err, rd_opcode, rd_op_a, rd_op_b, rd_result, 6 + i);
            end
        end
    endtask

    task automatic test_forward();
        drive_cycle(1'b1, 3'd1, 12, 0, 6, 6);
        n_tests++;
        if (rd_valid !== 1'b0 || rd_result !== 64'd0 || o_tuple !== e_tuple) begin
            n_fail++;
            $display("FAIL fwd_same_edge: got valid=%b result=%0d required valid=0 result=0", rd_valid, rd_result);
        end
        drive_cycle(1'b0, 3'd0, 0, 0, 0, 6);
        n_tests++;
        if (rd_valid !== 1'b1 || rd_result !== 64'd12 || o_tuple !== e_tuple) begin
            n_fail++;
            $display("FAIL fwd_next_edge: got valid=%b result=%0d required valid=1 result=12", rd_valid, rd_result);
        end
    endtask

    task automatic test_back_to_back();
        drive_cycle(1'b1, 3'd3, 1, 2, 8, 8);
        drive_cycle(1'b1, 3'd4, 1, 2, 8, 8);
        n_tests++;
        if (rd_valid !== 1'b1 || rd_result !== 64'd3 || o_tuple !== e_tuple) begin
            n_fail++;
            $display("FAIL b2b_first: got valid=%b result=%0d required valid=1 result=3", rd_valid, $signed(rd_result));
        end
        drive_cycle(1'b0, 3'd0, 0, 0, 0, 8);
        n_tests++;
        if (rd_valid !== 1'b1 || rd_result !== 64'hFFFF_FFFF_FFFF_FFFF || o_tuple !== e_tuple) begin
            n_fail++;
            $display("FAIL b2b_last_wins: got valid=%b result=%0d required valid=1 result=-1", rd_valid, $signed(rd_result));
        end
    endtask

    task automatic test_bounds();
        drive_cycle(1'b1, 3'd3, 100, 1, 25, 25);
        n_tests++;
        if (o_tuple !== 133'd0) begin
            n_fail++;
            $display("FAIL bounds_read25: got %h required 0", o_tuple);
        end
        drive_cycle(1'b0, 3'd0, 0, 0, 0, 25);
        n_tests++;
        if (o_tuple !== 133'd0) begin
            n_fail++;
            $display("FAIL bounds_read25_after: got %h required 0", o_tuple);
        end
        for (int i = 0; i < DEPTH; i++) begin
            drive_cycle(1'b0, 3'd0, 0, 0, 0, i);
            n_tests++;
            if (o_tuple !== e_tuple) begin
                n_fail++;
                $display("FAIL bounds_sweep[%0d]: got %h required %h", i, o_tuple, e_tuple);
            end
        end
    endtask

    task automatic test_mid_reset();
        drive_cycle(1'b1, 3'd1, 77, 0, 7, 0);
        load_en = 1'b0;
        reset_n = 1'b0;
        model_clear();
        #1;
        n_tests++;
        if ({rd_valid, rd_err, rd_opcode, rd_op_a, rd_op_b, rd_result} !== 133'd0) begin
            n_fail++;
            $display("FAIL mid_reset_async: got %h required 0", {rd_valid, rd_err, rd_opcode, rd_op_a, rd_op_b, rd_result});
        end
        #1;
        reset_n = 1'b1;
        drive_cycle(1'b0, 3'd0, 0, 0, 0, 7);
        n_tests++;
        if (rd_valid !== 1'b0 || o_tuple !== 133'd0) begin
            n_fail++;
            $display("FAIL mid_reset_addr7: got %h required 0", o_tuple);
        end
        drive_cycle(1'b0, 3'd0, 0, 0, 0, 0);
        n_tests++;
        if (rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_addr0: got valid=%b required 0", rd_valid);
        end
    endtask

    task automatic test_random();
        int a;
        int b;
        for (int n = 0; n < 400; n++) begin
            a = ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 400)) - 200;
            b = ($urandom_range(0, 5) == 0) ? 0 :
                (($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 60)) - 30);
            drive_cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, b,
                        $urandom_range(0, (1 << AW) - 1), $urandom_range(0, (1 << AW) - 1));
            n_tests++;
            if (o_tuple !== e_tuple) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h required %h", n, o_tuple, e_tuple);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef INSTR_REG_AUTO_PTR_EN
        test_auto_ptr();
`else
        test_arith();
        test_zero_div();
        test_forward();
        test_back_to_back();
        test_bounds();
        test_mid_reset();
        test_random();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_register_calc.md
Name: instr_register_calc

Overview:
Parametrised successor to the instruction register. It is a DEPTH-entry register file of {opcode, operand_a, operand_b} words that also computes and stores a signed result per entry, using a 2-stage write pipeline.
It has a registered read port with per-entry valid and error flags, and forwarding from the in-flight write. It sits between the stimulus side (load_en, pointers, operands) and the checking side, which compares read-back results.

Parameters:
OP_WIDTH, 32, signed operand width in bits
DEPTH, 32, number of entries (need not be a power of 2)
ADDR_WIDTH, $clog2(DEPTH) (minimum 1), pointer width
RES_WIDTH, 2*OP_WIDTH, signed result width

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous, active-low reset
load_en  input  1  write request, sampled on posedge clk
opcode  input  3  opcode_t encoding: 0 ZERO, 1 PASSA, 2 PASSB, 3 ADD, 4 SUB, 5 MULT, 6 DIV, 7 MOD
operand_a  input  OP_WIDTH  signed operand A
operand_b  input  OP_WIDTH  signed operand B
write_pointer  input  ADDR_WIDTH  write address
read_pointer  input  ADDR_WIDTH  read address, sampled every posedge
rd_opcode  output  3  stored opcode
rd_op_a  output  OP_WIDTH  stored operand A
rd_op_b  output  OP_WIDTH  stored operand B
rd_result  output  RES_WIDTH  stored result
rd_valid  output  1  addressed entry has been written since reset
rd_err  output  1  addressed entry was a divide or modulo by zero

Behaviour:
- Reset (asynchronous, active-low), takes effect immediately regardless of clk:
  - all entry valid bits cleared; stage-1 register invalidated.
  - all rd_* outputs driven to 0.
  - a write in flight when reset asserts is lost.
- Stage 1: at posedge T with load_en=1 and write_pointer<DEPTH, capture {opcode, operand_a, operand_b, write_pointer} and set s1_valid. If load_en=0, s1_valid=0.
- Stage 2: at posedge T+1, if s1_valid, write entry[s1_wp] with {opc, a, b, result, err} and set valid[s1_wp]=1.
- Back-to-back writes every cycle are supported.
- Result is computed from stage-1 contents; operands are sign-extended to RES_WIDTH:
  - ZERO=0, PASSA=a, PASSB=b, ADD=a+b, SUB=a-b, MULT=a*b (full width).
  - DIV truncates toward zero; MOD takes the sign of the dividend.
  - DIV or MOD with b=0: result=0, err=1. For every other case err=0.
- Read port: 1-cycle latency. At posedge T, rd_* are loaded with the following, in priority order:
  1. read_pointer>=DEPTH: all zeros, rd_valid=0.
  2. s1_valid and s1_wp==read_pointer: the forwarded stage-1 data with its computed result/err, rd_valid=1.
  3. valid[read_pointer]=0: all zeros, rd_valid=0.
  4. Otherwise: entry[read_pointer].
- Net effect: a read sampled at edge T sees every write whose load_en was sampled at T-1 or earlier. A write sampled at the same edge T is not visible to that read.
- Out-of-range write_pointer (>=DEPTH): write dropped, no state change.
- Same-address rewrite: the last write wins; valid stays 1.

Optional Feature:
Macro INSTR_REG_AUTO_PTR_EN.
- Defined:
  - write_pointer is ignored; an internal ADDR_WIDTH counter supplies the write address.
  - The counter resets to 0 and increments after each accepted write (load_en=1).
  - It wraps from DEPTH-1 to 0.
- Not defined: write_pointer is used as specified; no counter is present.

Test Plan:
- Reset: reset_n=0 for 2 cycles, then sweep read_pointer 0..DEPTH-1 -> every read returns all zeros with rd_valid=0.
- Arithmetic: write addr0 ADD(-15,7), addr1 MULT(-3,5), addr2 DIV(-7,2), addr3 MOD(-7,2); read back 0..3 -> rd_result -8, -15, -3, -1; rd_err=0; rd_valid=1.
- Zero divisor: write addr4 DIV(9,0), addr5 MOD(9,0) -> rd_result=0, rd_err=1 for both; opcode and operands stored unchanged.
- Forwarding: write addr6 PASSA(12) with load_en sampled at edge T.
  - read_pointer=6 sampled at T -> old contents (zeros, rd_valid=0).
  - read_pointer=6 sampled at T+1 -> rd_result=12, rd_valid=1.
- Bounds and reset mid-operation, with DEPTH=20:
  - write_pointer=25 -> no entry changes.
  - read_pointer=25 -> zeros, rd_valid=0.
  - reset_n pulsed low between posedge T and T+1 while a write to addr7 is in stage 1 -> addr7 reads rd_valid=0.
- INSTR_REG_AUTO_PTR_EN with DEPTH=4: 5 writes PASSB(1..5), write_pointer held at 3 -> addr0=5, addr1=2, addr2=3, addr3=4.
